csr_rmw_unit: RTL and testbench

// - Zicsr execution engine; drives the write port of the 16-entry CSR register file.
// - Reads that file's csr[0:15] output array.
// - Accepts CSRRW/RS/RC and immediate-variant requests from the core over valid/ready.
// - Does the read-modify-write and returns the old CSR value as rd data.
// - Sits between the core execute stage and the CSR register file; one access in flight.

---
 rtl/csr_pkg.sv | 40 ++++
 rtl/csr_rmw_alu.sv | 41 ++++
 rtl/csr_rmw_unit.sv | 135 +++++++++++++
 tb/tb_csr_rmw_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared types and sizes for the Zicsr read-modify-write engine.
// Contents: XLEN (from the global `XLEN macro), CSR file geometry,
// funct3 opcode encodings, FSM state encoding and the latched request payload.
`ifndef XLEN
`define XLEN 32
`endif

package csr_pkg;

  localparam int unsigned XLEN      = `XLEN;
  localparam int unsigned CSR_NUM   = 16;
  localparam int unsigned CSR_IDX_W = 4;
  localparam int unsigned OP_W      = 3;

  // funct3 encodings; 000 and 100 are deliberately absent (illegal)
  typedef enum logic [OP_W-1:0] {
    OP_RW  = 3'b001,
    OP_RS  = 3'b010,
    OP_RC  = 3'b011,
    OP_RWI = 3'b101,
    OP_RSI = 3'b110,
    OP_RCI = 3'b111
  } csr_op_e;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } csr_state_e;

  // Request payload captured at acceptance; op kept raw so illegal codes survive
  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic [CSR_IDX_W-1:0] index;
    logic [XLEN-1:0]      src;
    logic                 src_x0;
  } csr_req_t;

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational modify step of a CSR read-modify-write.
// Ports: i_op (funct3), i_old (current CSR value), i_src (rs1 or uimm),
//        i_src_x0 (rs1==x0 / uimm==0); o_new_c (value to write),
//        o_do_wr_c (instruction performs a write).
module csr_rmw_alu
  import csr_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_src,
  input  logic            i_src_x0,
  output logic [XLEN-1:0] o_new_c,
  output logic            o_do_wr_c
);

  logic [XLEN-1:0] w_src;

  // Immediate forms only carry a 5-bit uimm
  always_comb begin
    w_src = i_src;
    if (i_op == OP_RWI || i_op == OP_RSI || i_op == OP_RCI) begin
      w_src = XLEN'(i_src[4:0]);
    end
  end

  // RW/RWI always write; set/clear forms write only with a nonzero source operand
  always_comb begin
    o_new_c   = i_old;
    o_do_wr_c = !i_src_x0;
    case (i_op)
      OP_RW, OP_RWI: begin
        o_new_c   = w_src;
        o_do_wr_c = 1'b1;
      end
      OP_RS, OP_RSI: o_new_c = i_old | w_src;
      OP_RC, OP_RCI: o_new_c = i_old & ~w_src;
      default:       o_new_c = i_old;
    endcase
  end

endmodule

// File: rtl/csr_rmw_unit.sv
// Zicsr execution engine: accepts one CSR request at a time, reads the CSR
// file, performs the modify and drives the file's write port, then returns
// the old value (or an illegal-instruction flag) to the core.
// Ports: clk/rst (async active-high); req_* request channel (valid/ready);
//        rsp_* response channel (valid/ready); csr[] read view of the CSR
//        file; wreq/windex/wdata single-cycle write strobe into the file.
module csr_rmw_unit
  import csr_pkg::*;
#(
  parameter logic [CSR_NUM-1:0] RO_MASK = 16'h0001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OP_W-1:0]      req_op,
  input  logic [CSR_IDX_W-1:0] req_index,
  input  logic [XLEN-1:0]      req_src,
  input  logic                 req_src_x0,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 rsp_illegal,
  input  logic [XLEN-1:0]      csr [CSR_NUM],
  output logic                 wreq,
  output logic [CSR_IDX_W-1:0] windex,
  output logic [XLEN-1:0]      wdata
);

  csr_state_e           r_state, w_state_nxt;
  csr_req_t             r_req, w_req_nxt;
  logic                 r_wreq, w_wreq_nxt;
  logic [CSR_IDX_W-1:0] r_windex, w_windex_nxt;
  logic [XLEN-1:0]      r_wdata, w_wdata_nxt;
  logic                 r_rsp_valid, w_rsp_valid_nxt;
  logic [XLEN-1:0]      r_rsp_rdata, w_rsp_rdata_nxt;
  logic                 r_rsp_illegal, w_rsp_illegal_nxt;

  logic [XLEN-1:0]      w_old;
  logic [XLEN-1:0]      w_new;
  logic                 w_do_wr;
  logic                 w_bad_op;
  logic                 w_illegal;

  // Index 0 is hardwired to read as zero regardless of the file contents
  assign w_old = (r_req.index == '0) ? '0 : csr[r_req.index];

  csr_rmw_alu u_alu (
    .i_op      (r_req.op),
    .i_old     (w_old),
    .i_src     (r_req.src),
    .i_src_x0  (r_req.src_x0),
    .o_new_c   (w_new),
    .o_do_wr_c (w_do_wr)
  );

  assign w_bad_op  = (r_req.op == 3'b000) || (r_req.op == 3'b100);
  assign w_illegal = w_bad_op || (w_do_wr && RO_MASK[r_req.index]);

  assign req_ready   = (r_state == IDLE) && !rst;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_illegal = r_rsp_illegal;
  assign wreq        = r_wreq;
  assign windex      = r_windex;
  assign wdata       = r_wdata;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_req         <= '0;
      r_wreq        <= 1'b0;
      r_windex      <= '0;
      r_wdata       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_illegal <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_req         <= w_req_nxt;
      r_wreq        <= w_wreq_nxt;
      r_windex      <= w_windex_nxt;
      r_wdata       <= w_wdata_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_illegal <= w_rsp_illegal_nxt;
    end
  end

  // Next state and next registered outputs; wreq defaults low so it pulses once
  always_comb begin
    w_state_nxt       = r_state;
    w_req_nxt         = r_req;
    w_wreq_nxt        = 1'b0;
    w_windex_nxt      = r_windex;
    w_wdata_nxt       = r_wdata;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_illegal_nxt = r_rsp_illegal;
    case (r_state)
      IDLE: begin
        if (req_valid && req_ready) begin
          w_req_nxt   = '{op: req_op, index: req_index, src: req_src, src_x0: req_src_x0};
          w_state_nxt = READ;
        end
      end
      READ: begin
        w_rsp_rdata_nxt   = w_illegal ? '0 : w_old;
        w_rsp_illegal_nxt = w_illegal;
        if (w_illegal || !w_do_wr) begin
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = RESP;
        end else begin
          w_wreq_nxt   = 1'b1;
          w_windex_nxt = r_req.index;
          w_wdata_nxt  = w_new;
          w_state_nxt  = WRITE;
        end
      end
      WRITE: begin
        w_rsp_valid_nxt = 1'b1;
        w_state_nxt     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Self-checking bench for csr_rmw_unit: a CSR register file lives in the bench,
// a transaction-level model predicts each request's outcome and per-cycle outputs,
// and a negedge compare process checks the DUT against those expectations.
module tb_csr_rmw_unit;
  import csr_pkg::*;

  localparam logic [15:0] TB_RO_MASK = 16'h0001;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [OP_W-1:0]      req_op = '0;
  logic [CSR_IDX_W-1:0] req_index = '0;
  logic [XLEN-1:0]      req_src = '0;
  logic                 req_src_x0 = 1'b0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [XLEN-1:0]      rsp_rdata;
  logic                 rsp_illegal;
  logic                 wreq;
  logic [CSR_IDX_W-1:0] windex;
  logic [XLEN-1:0]      wdata;

  logic [XLEN-1:0] csr_file   [CSR_NUM];
  logic [XLEN-1:0] model_regs [CSR_NUM];

  logic                 load_en = 1'b0;
  logic [CSR_IDX_W-1:0] load_idx = '0;
  logic [XLEN-1:0]      load_val = '0;

  int checks = 0;
  int failures = 0;

  bit                   chk_en = 1'b0;
  logic                 exp_ready = 1'b0;
  logic                 exp_wreq = 1'b0;
  logic [CSR_IDX_W-1:0] exp_windex = '0;
  logic [XLEN-1:0]      exp_wdata = '0;
  logic                 exp_rv = 1'b0;
  logic [XLEN-1:0]      exp_rdata = '0;
  logic                 exp_ill = 1'b0;

  always #5 clk = ~clk;

  csr_rmw_unit #(.RO_MASK(TB_RO_MASK)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_index   (req_index),
    .req_src     (req_src),
    .req_src_x0  (req_src_x0),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_illegal (rsp_illegal),
    .csr         (csr_file),
    .wreq        (wreq),
    .windex      (windex),
    .wdata       (wdata)
  );

  // CSR register file environment: bench preload port plus the DUT write port
  always @(posedge clk) begin
    if (load_en) csr_file[load_idx] <= load_val;
    else if (wreq) csr_file[windex] <= wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model's expectations
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("wreq", 64'(wreq), 64'(exp_wreq));
      if (exp_wreq) begin
        chk("windex", 64'(windex), 64'(exp_windex));
        chk("wdata", 64'(wdata), 64'(exp_wdata));
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv) begin
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        chk("rsp_illegal", 64'(rsp_illegal), 64'(exp_ill));
      end
    end
  end

  // Architectural outcome of one Zicsr instruction against model_regs
  function automatic void predict(input logic [OP_W-1:0] op, input logic [CSR_IDX_W-1:0] idx,
                                  input logic [XLEN-1:0] src, input logic x0,
                                  output logic ill, output logic wr,
                                  output logic [XLEN-1:0] rd, output logic [XLEN-1:0] wd);
    logic [XLEN-1:0] old_v, s;
    logic bad, wants;
    old_v = (idx == 0) ? '0 : model_regs[idx];
    s = op[2] ? XLEN'(src[4:0]) : src;
    bad = 1'b0;
    wants = !x0;
    wd = old_v;
    case (op)
      3'b001, 3'b101: begin wd = s; wants = 1'b1; end
      3'b010, 3'b110: wd = old_v | s;
      3'b011, 3'b111: wd = old_v & ~s;
      default: bad = 1'b1;
    endcase
    ill = bad || (wants && TB_RO_MASK[idx]);
    wr = wants && !ill;
    rd = ill ? '0 : old_v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_ready = 1'b1;
    exp_wreq = 1'b0;
    exp_rv = 1'b0;
  endtask

  task automatic preload(input logic [CSR_IDX_W-1:0] idx, input logic [XLEN-1:0] val);
    load_en = 1'b1;
    load_idx = idx;
    load_val = val;
    model_regs[idx] = val;
    step();
    load_en = 1'b0;
  endtask

  task automatic busy_noise(input bit noise);
    req_valid = noise;
    if (noise) begin
      req_op = OP_W'($urandom_range(0, 7));
      req_index = CSR_IDX_W'($urandom_range(0, 15));
      req_src = XLEN'($urandom);
      req_src_x0 = 1'($urandom_range(0, 1));
    end
  endtask

  // One full transaction; called and returns in an IDLE cycle (posedge + 1)
  task automatic run_req(input logic [OP_W-1:0] op, input logic [CSR_IDX_W-1:0] idx,
                         input logic [XLEN-1:0] src, input logic x0,
                         input int stall, input bit noise);
    logic ill, wr;
    logic [XLEN-1:0] rd, wd;
    predict(op, idx, src, x0, ill, wr, rd, wd);
    req_valid = 1'b1; req_op = op; req_index = idx; req_src = src; req_src_x0 = x0;
    rsp_ready = 1'b0;
    set_idle_exp();
    step();                               // N+1
    exp_ready = 1'b0;
    busy_noise(noise);
    rsp_ready = 1'($urandom_range(0, 1)); // ignored outside RESP
    step();                               // N+2
    if (wr) begin
      exp_wreq = 1'b1; exp_windex = idx; exp_wdata = wd;
      busy_noise(noise);
      rsp_ready = 1'($urandom_range(0, 1));
      step();                             // N+3
      exp_wreq = 1'b0;
      model_regs[idx] = wd;
    end
    exp_rv = 1'b1; exp_rdata = rd; exp_ill = ill;
    rsp_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      busy_noise(noise);
      step();
    end
    rsp_ready = 1'b1;
    step();                               // back to IDLE
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    set_idle_exp();
  endtask

  task automatic pin(input string name, input logic [OP_W-1:0] op, input logic [CSR_IDX_W-1:0] idx,
                     input logic [XLEN-1:0] src, input logic x0,
                     input logic e_ill, input logic e_wr, input logic [XLEN-1:0] e_rd,
                     input logic [XLEN-1:0] e_wd);
    logic ill, wr;
    logic [XLEN-1:0] rd, wd;
    predict(op, idx, src, x0, ill, wr, rd, wd);
    chk({name, "_ill"}, 64'(ill), 64'(e_ill));
    chk({name, "_wr"}, 64'(wr), 64'(e_wr));
    chk({name, "_rd"}, 64'(rd), 64'(e_rd));
    if (e_wr) chk({name, "_wd"}, 64'(wd), 64'(e_wd));
  endtask

  initial begin
    logic [OP_W-1:0] r_op;
    logic [XLEN-1:0] r_src;
    logic r_x0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_wreq", 64'(wreq), 64'd0);
    chk("rst_windex", 64'(windex), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_illegal", 64'(rsp_illegal), 64'd0);
    step();
    step();
    chk("rst_held_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    step();
    chk("rel_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < int'(CSR_NUM); i++) preload(CSR_IDX_W'(i), XLEN'($urandom));
    preload(4'd3, XLEN'(32'h1234_5678));
    preload(4'd5, XLEN'(32'h0000_000F));
    set_idle_exp();
    chk_en = 1'b1;

    // Directed cases, each model prediction pinned to hand-computed values
    pin("rw3", 3'b001, 4'd3, XLEN'(32'hDEAD_BEEF), 1'b0, 1'b0, 1'b1, XLEN'(32'h1234_5678), XLEN'(32'hDEAD_BEEF));
    run_req(3'b001, 4'd3, XLEN'(32'hDEAD_BEEF), 1'b0, 0, 1'b0);
    chk("rw3_file", 64'(csr_file[3]), 64'h0000_0000_DEAD_BEEF);
    pin("rs5", 3'b010, 4'd5, XLEN'(32'h0F0), 1'b0, 1'b0, 1'b1, XLEN'(32'h00F), XLEN'(32'h0FF));
    run_req(3'b010, 4'd5, XLEN'(32'h0F0), 1'b0, 1, 1'b0);
    pin("rc5", 3'b011, 4'd5, XLEN'(32'h00F), 1'b0, 1'b0, 1'b1, XLEN'(32'h0FF), XLEN'(32'h0F0));
    run_req(3'b011, 4'd5, XLEN'(32'h00F), 1'b0, 0, 1'b0);
    pin("rsi5_x0", 3'b110, 4'd5, XLEN'(0), 1'b1, 1'b0, 1'b0, XLEN'(32'h0F0), XLEN'(0));
    run_req(3'b110, 4'd5, XLEN'(0), 1'b1, 0, 1'b0);
    pin("op100", 3'b100, 4'd2, XLEN'(32'h55), 1'b0, 1'b1, 1'b0, XLEN'(0), XLEN'(0));
    run_req(3'b100, 4'd2, XLEN'(32'h55), 1'b0, 0, 1'b0);
    pin("rw0", 3'b001, 4'd0, XLEN'(32'h77), 1'b0, 1'b1, 1'b0, XLEN'(0), XLEN'(0));
    run_req(3'b001, 4'd0, XLEN'(32'h77), 1'b0, 0, 1'b0);
    pin("rs0_x0", 3'b010, 4'd0, XLEN'(0), 1'b1, 1'b0, 1'b0, XLEN'(0), XLEN'(0));
    run_req(3'b010, 4'd0, XLEN'(0), 1'b1, 0, 1'b0);
    pin("rwi7", 3'b101, 4'd7, XLEN'(32'h1F), 1'b0, 1'b0, 1'b1, model_regs[7], XLEN'(32'h1F));
    run_req(3'b101, 4'd7, XLEN'(32'h1F), 1'b0, 0, 1'b0);
    pin("rwi8_mask", 3'b101, 4'd8, XLEN'(32'hFFFF_FFE3), 1'b0, 1'b0, 1'b1, model_regs[8], XLEN'(32'h03));
    run_req(3'b101, 4'd8, XLEN'(32'hFFFF_FFE3), 1'b0, 0, 1'b0);

    // Backpressure with a request held by the core while busy
    run_req(3'b010, 4'd6, XLEN'(32'hA0), 1'b0, 5, 1'b1);
    run_req(3'b001, 4'd6, XLEN'(32'h1), 1'b0, 0, 1'b0);

    // Reset asserted during the write cycle
    preload(4'd9, XLEN'(32'hCAFE_0009));
    req_valid = 1'b1; req_op = 3'b001; req_index = 4'd9; req_src = XLEN'(32'h9999); req_src_x0 = 1'b0;
    step();
    req_valid = 1'b0;
    exp_ready = 1'b0;
    step();
    exp_wreq = 1'b1; exp_windex = 4'd9; exp_wdata = XLEN'(32'h9999);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstw_wreq", 64'(wreq), 64'd0);
    chk("rstw_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstw_req_ready", 64'(req_ready), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("rstw_rel_ready", 64'(req_ready), 64'd1);
    chk("rstw_file", 64'(csr_file[9]), 64'h0000_0000_CAFE_0009);
    set_idle_exp();
    chk_en = 1'b1;
    run_req(3'b011, 4'd9, XLEN'(32'h0009), 1'b0, 0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      r_op = OP_W'($urandom_range(0, 7));
      r_x0 = ($urandom_range(0, 3) == 0);
      r_src = XLEN'($urandom);
      if (r_x0) begin
        if (r_op[2]) r_src[4:0] = 5'd0;
        else r_src = '0;
      end
      run_req(r_op, CSR_IDX_W'($urandom_range(0, 15)), r_src, r_x0,
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) step();
    end

    chk_en = 1'b0;
    for (int i = 1; i < int'(CSR_NUM); i++) chk("final_file", 64'(csr_file[i]), 64'(model_regs[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
